// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port: one request pulse per fetch, one rvalid pulse per request.
interface instr_fetch_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  imem_req;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic                  imem_rvalid;
    logic [31:0]           imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, issues one instruction-memory read at a time and
// presents the returned word split into decode fields, with stall and redirect.
module instr_fetch_unit #(
    parameter int                    WIDTH_OP   = 7,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    instr_fetch_unit_if.master    imem,
    input  logic                  stall,
    input  logic                  redirect_en,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  inst_valid,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic [WIDTH_OP-1:0]   opcode,
    output logic [4:0]            rd,
    output logic [2:0]            func3,
    output logic [4:0]            rs1,
    output logic [4:0]            rs2,
    output logic [WIDTH_OP-1:0]   func7,
    output logic [19:0]           immidiate_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]           ir_q, ir_d;
    logic [ADDR_WIDTH-1:0] inst_pc_q, inst_pc_d;
    logic                  inst_valid_q, inst_valid_d;
    logic                  imem_req_q, imem_req_d;
    logic [ADDR_WIDTH-1:0] redirect_tgt;

    // Low two bits of the redirect target are dropped to keep fetches word-aligned.
    assign redirect_tgt = redirect_pc & ~ADDR_WIDTH'(3);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;

        if (redirect_en) begin
            // Redirect wins over stall and rvalid; any in-flight read must be drained.
            pc_d         = redirect_tgt;
            inst_valid_d = 1'b0;
            case (state_q)
                S_REQ:   state_d = S_DRAIN;
                S_WAIT:  state_d = imem.imem_rvalid ? S_REQ : S_DRAIN;
                S_DRAIN: state_d = S_DRAIN;
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_IDLE: state_d = S_REQ;
                S_REQ:  state_d = S_WAIT;
                S_WAIT: begin
                    if (imem.imem_rvalid) begin
                        ir_d         = imem.imem_rdata;
                        inst_pc_d    = pc_q;
                        pc_d         = pc_q + ADDR_WIDTH'(4);
                        inst_valid_d = 1'b1;
                        state_d      = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        inst_valid_d = 1'b0;
                        state_d      = S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem.imem_rvalid) state_d = S_REQ;
                end
                default: state_d = S_IDLE;
            endcase
        end

        imem_req_d = (state_d == S_REQ);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            ir_q         <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
            imem_req_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            imem_req_q   <= imem_req_d;
        end
    end

    // pc only moves on capture or redirect, so it still names the issued word while req is high.
    assign imem.imem_req  = imem_req_q;
    assign imem.imem_addr = pc_q;

    assign inst_valid     = inst_valid_q;
    assign inst_pc        = inst_pc_q;
    assign opcode         = ir_q[WIDTH_OP-1:0];
    assign rd             = ir_q[11:7];
    assign func3          = ir_q[14:12];
    assign rs1            = ir_q[19:15];
    assign rs2            = ir_q[24:20];
    assign func7          = ir_q[31 -: WIDTH_OP];
    assign immidiate_data = ir_q[31:12];

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage, directly upstream of the control unit. Holds the program counter and issues one word-read at a time to instruction memory. Latches the returned 32-bit instruction and presents it already split into fields: opcode, func3, func7, rd, rs1, rs2 and the 20-bit upper immediate. Downstream decode, register file and ALU consume these fields, with back-pressure from downstream (stall) and PC redirect from branch/jump resolution.

## Interface
- WIDTH_OP, 7, opcode/func7 field width.
- ADDR_WIDTH, 32, PC and instruction-memory address width.
- RESET_PC, 0, PC value after reset. Bits [1:0] must be 0.

- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  read request, high for exactly one cycle per fetch.
- imem_addr  out  ADDR_WIDTH  word-aligned fetch address, valid while imem_req=1.
- imem_rvalid  in  1  read data valid; one pulse per request, ≥1 cycle after imem_req.
- imem_rdata  in  32  instruction word, sampled when imem_rvalid=1.
- stall  in  1  downstream not ready; holds the current instruction.
- redirect_en  in  1  one-cycle pulse; load PC from redirect_pc.
- redirect_pc  in  ADDR_WIDTH  redirect target; bits [1:0] ignored and forced to 0.
- inst_valid  out  1  fields below hold an unconsumed instruction.
- inst_pc  out  ADDR_WIDTH  address of the presented instruction.
- opcode  out  WIDTH_OP  IR[6:0].
- rd  out  5  IR[11:7].
- func3  out  3  IR[14:12].
- rs1  out  5  IR[19:15].
- rs2  out  5  IR[24:20].
- func7  out  WIDTH_OP  IR[31:25].
- immidiate_data  out  20  IR[31:12].

## Operation
- State register plus PC register plus 32-bit instruction register (IR). All field outputs are wire slices of IR.
- The FSM has five states.
  - S_IDLE: entered on reset. Unconditionally goes to S_REQ next cycle.
  - S_REQ: drives imem_req=1 and imem_addr=pc. Goes to S_WAIT.
  - S_WAIT: waits for imem_rvalid. On imem_rvalid: IR<=imem_rdata, inst_pc<=pc, pc<=pc+4, inst_valid<=1, then go to S_HOLD.
  - S_HOLD: inst_valid=1. The instruction is consumed on any edge where stall=0; then inst_valid<=0 and go to S_REQ. While stall=1, stay in S_HOLD with IR, inst_pc and inst_valid unchanged.
  - S_DRAIN: a request is outstanding but its data is unwanted. On imem_rvalid, discard the data and go to S_REQ.
- PC arithmetic is modulo 2^ADDR_WIDTH: pc=2^ADDR_WIDTH−4 increments to 0. pc[1:0] is always 0.
- Redirect has priority over stall and over rvalid. Any cycle with redirect_en=1 sets pc<=redirect_pc with [1:0] zeroed and inst_valid<=0. The next state depends on the current state:
  - S_IDLE or S_HOLD: go to S_REQ.
  - S_REQ: the request for the old pc was already issued, so go to S_DRAIN.
  - S_WAIT without rvalid: go to S_DRAIN.
  - S_WAIT with rvalid in the same cycle: data discarded, IR unchanged, go to S_REQ.
  - S_DRAIN: stay in S_DRAIN; the new pc replaces the old target.
- imem_rvalid in S_IDLE, S_REQ or S_HOLD is ignored; there is no state or IR change.
- IR and inst_pc keep their last values after consumption or redirect. Only inst_valid qualifies them.
- No more than one memory request is ever outstanding.

## Timing
- Reset values:
  - state=S_IDLE, pc=RESET_PC.
  - IR=0, so every field output is 0.
  - inst_pc=0, inst_valid=0, imem_req=0, imem_addr=RESET_PC.
- Asserting reset_n mid-fetch aborts immediately. A response arriving after reset deasserts is ignored, because it arrives in S_IDLE or S_REQ.
- The first imem_req is in the 2nd cycle after reset_n deasserts.
- Latency: imem_req in cycle t; earliest imem_rvalid at t+1; inst_valid high from t+2.
- Throughput with zero-wait memory and stall=0 is one instruction per 3 cycles (S_REQ → S_WAIT → S_HOLD). Each memory wait cycle adds one cycle; each stall cycle adds one cycle.
- Outputs are registered. imem_req and imem_addr are decoded from the state register and pc only, not from any input.

## Test plan
- Reset then run, with memory returning 0x00500093 one cycle after each req and stall=0:
  - imem_addr sequence is 0x0, 0x4, 0x8.
  - On each inst_valid: opcode=0x13, rd=1, func3=0, rs1=0, immidiate_data=0x00500.
- R-type 0x40208033 returned with stall held high for 4 cycles:
  - inst_valid, IR and fields stay constant: func7=0x20, rs2=2, rs1=1, rd=0, opcode=0x33.
  - No imem_req while stalled.
  - Next req comes 1 cycle after stall drops.
- Memory wait of 5 cycles: inst_valid rises exactly 1 cycle after imem_rvalid, and imem_req is not reasserted during the wait.
- Redirect to 0x103 while in S_WAIT:
  - The returning word for the old pc is dropped; inst_valid stays 0.
  - Next imem_addr=0x100.
  - Also cover redirect coincident with rvalid, which goes directly to S_REQ.
- PC wrap, with RESET_PC=0xFFFFFFFC: first fetch at 0xFFFFFFFC, second at 0x00000000.
- reset_n pulsed low in S_WAIT, then a late imem_rvalid: it is ignored, all outputs return to reset values, and fetching restarts at RESET_PC.
